// File: rtl/dbg_stream_buffer.sv
// rtl/dbg_stream_buffer.sv - bidirectional byte FIFO bridge for the debug bytestream channel
// TX carries SoC->host bytes, RX carries host->SoC bytes; both expose levels and byte counters.
module dbg_stream_buffer #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               soc_tx_data,
  input  logic                     soc_tx_has_data,
  output logic                     soc_tx_consume,
  output logic [7:0]               host_tx_data,
  output logic                     host_tx_has_data,
  input  logic                     host_tx_consume,
  input  logic [7:0]               host_rx_data,
  input  logic                     host_rx_produce,
  output logic                     host_rx_has_space,
  output logic [7:0]               soc_rx_data,
  output logic                     soc_rx_produce,
  input  logic                     soc_rx_has_space,
  input  logic                     stat_clear,
  output logic [TX_DEPTH_LOG2:0]   tx_level,
  output logic [RX_DEPTH_LOG2:0]   rx_level,
  output logic [31:0]              tx_bytes,
  output logic [31:0]              rx_bytes,
  output logic                     rx_drop
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  logic [7:0]             r_tx_mem [TX_DEPTH];
  logic [7:0]             r_rx_mem [RX_DEPTH];
  logic [TX_DEPTH_LOG2:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [RX_DEPTH_LOG2:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [31:0]            r_tx_bytes, r_rx_bytes;
  logic                   r_rx_drop;

  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_overrun;

  assign w_tx_empty = (r_tx_wr_ptr == r_tx_rd_ptr);
  assign w_tx_full  = (r_tx_wr_ptr[TX_DEPTH_LOG2] != r_tx_rd_ptr[TX_DEPTH_LOG2]) &&
                      (r_tx_wr_ptr[TX_DEPTH_LOG2-1:0] == r_tx_rd_ptr[TX_DEPTH_LOG2-1:0]);
  assign w_rx_empty = (r_rx_wr_ptr == r_rx_rd_ptr);
  assign w_rx_full  = (r_rx_wr_ptr[RX_DEPTH_LOG2] != r_rx_rd_ptr[RX_DEPTH_LOG2]) &&
                      (r_rx_wr_ptr[RX_DEPTH_LOG2-1:0] == r_rx_rd_ptr[RX_DEPTH_LOG2-1:0]);

  // Ready-style outputs are also gated by reset so they read 0 while it is held.
  assign w_tx_push    = reset & soc_tx_has_data & ~w_tx_full;
  assign w_tx_pop     = host_tx_consume & ~w_tx_empty;
  assign w_rx_push    = reset & host_rx_produce & ~w_rx_full;
  assign w_rx_overrun = host_rx_produce & w_rx_full;
  assign w_rx_pop     = soc_rx_has_space & ~w_rx_empty;

  assign soc_tx_consume    = w_tx_push;
  assign host_tx_has_data  = ~w_tx_empty;
  assign host_tx_data      = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd_ptr[TX_DEPTH_LOG2-1:0]];
  assign host_rx_has_space = reset & ~w_rx_full;
  assign soc_rx_produce    = w_rx_pop;
  assign soc_rx_data       = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rd_ptr[RX_DEPTH_LOG2-1:0]];

  assign tx_level = r_tx_wr_ptr - r_tx_rd_ptr;
  assign rx_level = r_rx_wr_ptr - r_rx_rd_ptr;
  assign tx_bytes = r_tx_bytes;
  assign rx_bytes = r_rx_bytes;
  assign rx_drop  = r_rx_drop;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr[TX_DEPTH_LOG2-1:0]] <= soc_tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr[RX_DEPTH_LOG2-1:0]] <= host_rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
    end
  end

  // A clear wins over any transfer or drop landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_bytes <= '0;
      r_rx_bytes <= '0;
      r_rx_drop  <= 1'b0;
    end else if (stat_clear) begin
      r_tx_bytes <= '0;
      r_rx_bytes <= '0;
      r_rx_drop  <= 1'b0;
    end else begin
      if (w_tx_pop)     r_tx_bytes <= r_tx_bytes + 32'd1;
      if (w_rx_push)    r_rx_bytes <= r_rx_bytes + 32'd1;
      if (w_rx_overrun) r_rx_drop  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dbg_stream_buffer.sv
// tb/tb_dbg_stream_buffer.sv - directed self-checking bench for dbg_stream_buffer
module tb_dbg_stream_buffer;
  logic        clk;
  logic        reset;
  logic [7:0]  soc_tx_data;
  logic        soc_tx_has_data;
  logic        soc_tx_consume;
  logic [7:0]  host_tx_data;
  logic        host_tx_has_data;
  logic        host_tx_consume;
  logic [7:0]  host_rx_data;
  logic        host_rx_produce;
  logic        host_rx_has_space;
  logic [7:0]  soc_rx_data;
  logic        soc_rx_produce;
  logic        soc_rx_has_space;
  logic        stat_clear;
  logic [4:0]  tx_level;
  logic [4:0]  rx_level;
  logic [31:0] tx_bytes;
  logic [31:0] rx_bytes;
  logic        rx_drop;

  int n_checks = 0;
  int n_fail   = 0;

  dbg_stream_buffer #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .soc_tx_data       (soc_tx_data),
    .soc_tx_has_data   (soc_tx_has_data),
    .soc_tx_consume    (soc_tx_consume),
    .host_tx_data      (host_tx_data),
    .host_tx_has_data  (host_tx_has_data),
    .host_tx_consume   (host_tx_consume),
    .host_rx_data      (host_rx_data),
    .host_rx_produce   (host_rx_produce),
    .host_rx_has_space (host_rx_has_space),
    .soc_rx_data       (soc_rx_data),
    .soc_rx_produce    (soc_rx_produce),
    .soc_rx_has_space  (soc_rx_has_space),
    .stat_clear        (stat_clear),
    .tx_level          (tx_level),
    .rx_level          (rx_level),
    .tx_bytes          (tx_bytes),
    .rx_bytes          (rx_bytes),
    .rx_drop           (rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] q[$];
  int sent, rcvd, cyc, stalls, maxl;
  logic [7:0] b;

  initial begin
    reset = 1'b0;
    soc_tx_data = 8'h00; soc_tx_has_data = 1'b0; host_tx_consume = 1'b0;
    host_rx_data = 8'h00; host_rx_produce = 1'b0; soc_rx_has_space = 1'b0;
    stat_clear = 1'b0;

    // 1: reset and idle
    repeat (2) @(negedge clk);
    check_eq("rst_held_has_space", host_rx_has_space, 0);
    reset = 1'b1;
    repeat (10) tick();
    check_eq("idle_has_space", host_rx_has_space, 1);
    check_eq("idle_tx_has_data", host_tx_has_data, 0);
    check_eq("idle_tx_data", host_tx_data, 0);
    check_eq("idle_soc_rx_produce", soc_rx_produce, 0);
    check_eq("idle_soc_rx_data", soc_rx_data, 0);
    check_eq("idle_soc_tx_consume", soc_tx_consume, 0);
    check_eq("idle_levels", {tx_level, rx_level}, 0);
    check_eq("idle_tx_bytes", tx_bytes, 0);
    check_eq("idle_rx_bytes", rx_bytes, 0);
    check_eq("idle_rx_drop", rx_drop, 0);

    // 2: fill TX then drain in order
    for (int i = 0; i < 16; i++) begin
      soc_tx_has_data = 1'b1; soc_tx_data = 8'(i);
      #1 check_eq("t2_consume", soc_tx_consume, 1);
      tick();
    end
    check_eq("t2_level_full", tx_level, 16);
    soc_tx_data = 8'h10;
    #1 check_eq("t2_consume_full", soc_tx_consume, 0);
    tick();
    check_eq("t2_level_still_full", tx_level, 16);
    soc_tx_has_data = 1'b0;
    host_tx_consume = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_has_data", host_tx_has_data, 1);
      check_eq("t2_data", host_tx_data, 32'(i));
      tick();
    end
    host_tx_consume = 1'b0;
    check_eq("t2_tx_bytes", tx_bytes, 16);
    check_eq("t2_level_empty", tx_level, 0);
    check_eq("t2_has_data_empty", host_tx_has_data, 0);

    // 3: streaming with random gaps, host consumes whenever data is present
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    check_eq("t3_cleared", tx_bytes, 0);
    sent = 0; rcvd = 0; cyc = 0; stalls = 0; maxl = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      host_tx_consume = host_tx_has_data;
      if (host_tx_has_data) begin
        if (q.size() == 0) check_eq("t3_underflow", q.size(), 1);
        else begin
          b = q.pop_front();
          check_eq("t3_data", host_tx_data, b);
          rcvd++;
        end
      end
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        soc_tx_has_data = 1'b1; soc_tx_data = 8'($urandom);
      end else soc_tx_has_data = 1'b0;
      #1;
      if (soc_tx_has_data) begin
        if (!soc_tx_consume) stalls++;
        else begin q.push_back(soc_tx_data); sent++; end
      end
      if (int'(tx_level) > maxl) maxl = int'(tx_level);
      @(negedge clk);
      cyc++;
    end
    soc_tx_has_data = 1'b0; host_tx_consume = 1'b0;
    check_eq("t3_rcvd", rcvd, 1000);
    check_eq("t3_stalls", stalls, 0);
    check_eq("t3_max_level_le1", maxl <= 1, 1);
    check_eq("t3_tx_bytes", tx_bytes, 1000);
    check_eq("t3_level", tx_level, 0);

    // 4: RX overrun while SoC not ready, then drain
    for (int i = 0; i < 20; i++) begin
      host_rx_produce = 1'b1; host_rx_data = 8'(8'h20 + i);
      #1 check_eq("t4_has_space", host_rx_has_space, (i < 16) ? 1 : 0);
      check_eq("t4_soc_rx_produce_blocked", soc_rx_produce, 0);
      tick();
    end
    host_rx_produce = 1'b0;
    check_eq("t4_rx_level", rx_level, 16);
    check_eq("t4_rx_drop", rx_drop, 1);
    check_eq("t4_rx_bytes", rx_bytes, 16);
    soc_rx_has_space = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 check_eq("t4_produce", soc_rx_produce, 1);
      check_eq("t4_data", soc_rx_data, 32'h20 + i);
      tick();
    end
    check_eq("t4_rx_level_empty", rx_level, 0);
    check_eq("t4_produce_empty", soc_rx_produce, 0);
    soc_rx_has_space = 1'b0;

    // 5: async reset with TX partly full
    for (int i = 0; i < 5; i++) begin
      soc_tx_has_data = 1'b1; soc_tx_data = 8'(8'h50 + i); tick();
    end
    soc_tx_has_data = 1'b0;
    check_eq("t5_level5", tx_level, 5);
    #2 reset = 1'b0;
    #1 check_eq("t5_has_data_in_reset", host_tx_has_data, 0);
    check_eq("t5_level_in_reset", tx_level, 0);
    check_eq("t5_counters_in_reset", tx_bytes, 0);
    @(negedge clk);
    reset = 1'b1;
    host_tx_consume = 1'b1;
    repeat (3) begin
      check_eq("t5_no_emerge", host_tx_has_data, 0);
      check_eq("t5_data_zero", host_tx_data, 0);
      tick();
    end
    host_tx_consume = 1'b0;
    check_eq("t5_level_after", tx_level, 0);
    check_eq("t5_rx_drop_after", rx_drop, 0);
    check_eq("t5_has_space_after", host_rx_has_space, 1);

    // 6: stat_clear coincident with host pop and RX drop
    for (int i = 0; i < 3; i++) begin
      soc_tx_has_data = 1'b1; soc_tx_data = 8'(8'hA0 + i); tick();
    end
    soc_tx_has_data = 1'b0;
    host_tx_consume = 1'b1; tick(); host_tx_consume = 1'b0;
    check_eq("t6_tx_bytes_pre", tx_bytes, 1);
    for (int i = 0; i < 16; i++) begin
      host_rx_produce = 1'b1; host_rx_data = 8'(i); tick();
    end
    check_eq("t6_rx_full", rx_level, 16);
    check_eq("t6_rx_bytes_pre", rx_bytes, 16);
    stat_clear = 1'b1; host_tx_consume = 1'b1;
    tick();
    stat_clear = 1'b0; host_tx_consume = 1'b0; host_rx_produce = 1'b0;
    check_eq("t6_tx_bytes", tx_bytes, 0);
    check_eq("t6_rx_bytes", rx_bytes, 0);
    check_eq("t6_rx_drop", rx_drop, 0);
    check_eq("t6_tx_level", tx_level, 1);
    check_eq("t6_rx_level", rx_level, 16);
    check_eq("t6_head", host_tx_data, 32'hA2);
    host_rx_produce = 1'b1; tick(); host_rx_produce = 1'b0;
    check_eq("t6_drop_after_clear", rx_drop, 1);
    check_eq("t6_rx_bytes_after_drop", rx_bytes, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
